// File: rtl/tcnd_v2_pkg.sv
// tcnd_v2 shared definitions: condition-code width and encodings.
// Imported by the interface, the return stack and the top.
package tcnd_v2_pkg;

    localparam int CCW = 4;

    typedef logic [CCW-1:0] cc_t;

    localparam cc_t CC_NONE = 4'd0;
    localparam cc_t CC_RET  = 4'd1;
    localparam cc_t CC_JMP  = 4'd2;
    localparam cc_t CC_CALL = 4'd3;
    localparam cc_t CC_JZ   = 4'd4;
    localparam cc_t CC_JNZ  = 4'd5;
    localparam cc_t CC_JC   = 4'd6;
    localparam cc_t CC_JNC  = 4'd7;
    localparam cc_t CC_JN   = 4'd8;
    localparam cc_t CC_JNN  = 4'd9;

endpackage

// File: rtl/tcnd_v2_if.sv
// Branch request/response bundle between control path and tcnd_v2.
// master: br_en, contl, aluo, flag_we, ret_addr, tgt_addr -> ; <- tcnd, br_addr
interface tcnd_v2_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    import tcnd_v2_pkg::*;

    logic          br_en;
    cc_t           contl;
    logic [DW:0]   aluo;
    logic          flag_we;
    logic [AW-1:0] ret_addr;
    logic [AW-1:0] tgt_addr;
    logic          tcnd;
    logic [AW-1:0] br_addr;

    modport master (
        output br_en, contl, aluo, flag_we, ret_addr, tgt_addr,
        input  tcnd, br_addr
    );

    modport slave (
        input  br_en, contl, aluo, flag_we, ret_addr, tgt_addr,
        output tcnd, br_addr
    );

endinterface

// File: rtl/tcnd_v2_ret_stack.sv
// Return-address LIFO, AW x DEPTH, with occupancy count sp (0..DEPTH).
// Ports: clk, rst_n, push, pop, din -> top, full, empty, sp.
module tcnd_v2_ret_stack #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [AW-1:0]          din,
    output logic [AW-1:0]          top,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] sp
);
    localparam int IW = $clog2(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [IW-1:0] wi;
    logic [IW-1:0] ri;

    // At sp=DEPTH the low bits wrap to 0, so ri still lands on DEPTH-1.
    assign wi    = sp[IW-1:0];
    assign ri    = wi - IW'(1);
    assign top   = mem[ri];
    assign full  = (sp == (IW+1)'(DEPTH));
    assign empty = (sp == '0);

    // Contents are cleared too so top is never X when read as don't-care.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            mem[wi] <= din;
            sp      <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

endmodule

// File: rtl/tcnd_v2.sv
// Branch-condition unit: decodes contl against flags, drives tcnd/br_addr.
// Ports: clk, rst_n, bus (slave), err_clr -> zf, cf, nf, sp, ovf, unf.
module tcnd_v2
    import tcnd_v2_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int DEPTH    = 4,
    parameter int FLAG_SRC = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tcnd_v2_if.slave               bus,
    input  logic                   err_clr,
    output logic                   zf,
    output logic                   cf,
    output logic                   nf,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   ovf,
    output logic                   unf
);
    logic          lz, lc, ln;
    logic          ez, ec, en;
    logic          full, empty;
    logic          push, pop;
    logic          ovf_set, unf_set;
    logic          tk;
    logic [AW-1:0] top;

    assign lz = ~|bus.aluo[DW-1:0];
    assign lc = bus.aluo[DW];
    assign ln = bus.aluo[DW-1];

    assign ez = (FLAG_SRC != 0) ? zf : lz;
    assign ec = (FLAG_SRC != 0) ? cf : lc;
    assign en = (FLAG_SRC != 0) ? nf : ln;

    tcnd_v2_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (bus.ret_addr),
        .top   (top),
        .full  (full),
        .empty (empty),
        .sp    (sp)
    );

    always_comb begin
        tk      = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (bus.br_en) begin
            case (bus.contl)
                CC_RET: begin
                    tk      = !empty;
                    pop     = !empty;
                    unf_set = empty;
                end
                CC_JMP:  tk = 1'b1;
                CC_CALL: begin
                    tk      = !full;
                    push    = !full;
                    ovf_set = full;
                end
                CC_JZ:   tk = ez;
                CC_JNZ:  tk = !ez;
                CC_JC:   tk = ec;
                CC_JNC:  tk = !ec;
                CC_JN:   tk = en;
                CC_JNN:  tk = !en;
                default: tk = 1'b0;
            endcase
        end
    end

    assign bus.tcnd    = tk;
    assign bus.br_addr = (bus.br_en && bus.contl == CC_RET) ? top
                                                             : bus.tgt_addr;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zf  <= 1'b0;
            cf  <= 1'b0;
            nf  <= 1'b0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (bus.flag_we) begin
                zf <= lz;
                cf <= lc;
                nf <= ln;
            end
            if (ovf_set)      ovf <= 1'b1;
            else if (err_clr) ovf <= 1'b0;
            if (unf_set)      unf <= 1'b1;
            else if (err_clr) unf <= 1'b0;
        end
    end

endmodule

// File: doc/tcnd_v2.md
Name: tcnd_v2

Overview:
Parametrised next-generation branch-condition unit for the CPU control path. It evaluates the 4-bit control code against ALU result and flags, and selects the branch target. It adds four things: registered Z/C/N flags, extra condition codes, an internal return-address stack for CALL/RET, and sticky stack-error flags. It sits between the ALU output and the program-counter mux.

Parameters:
DW, 8, ALU data width; aluo is DW+1 bits, with bit DW as carry.
AW, 8, program-address width.
DEPTH, 4, return-stack entries (power of 2, at least 2).
FLAG_SRC, 0, 0 = conditions use live aluo; 1 = conditions use registered flags.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
br_en  in  1  instruction valid; contl is evaluated and state is updated only when br_en=1
contl  in  4  condition/operation code
aluo  in  DW+1  ALU result {carry, data}
flag_we  in  1  latch Z/C/N from aluo
ret_addr  in  AW  return address pushed on CALL (pc+1)
tgt_addr  in  AW  jump/call target from instruction
tcnd  out  1  branch taken
br_addr  out  AW  address to load into PC when tcnd=1
zf, cf, nf  out  1 each  registered flags
sp  out  $clog2(DEPTH)+1  stack occupancy, 0..DEPTH
ovf  out  1  sticky: CALL attempted with stack full
unf  out  1  sticky: RET attempted with stack empty
err_clr  in  1  clears ovf/unf

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low. All state updates on the rising edge of clk.
- Reset (rst_n=0 at an edge): zf=cf=nf=0, sp=0, ovf=unf=0, stack contents undefined. Reset overrides every other input, including reset during CALL/RET.
- Flag sources:
  - Live flags: Z=~|aluo[DW-1:0], C=aluo[DW], N=aluo[DW-1].
  - Registered flags: on flag_we=1, zf/cf/nf take the live values. flag_we operates independently of br_en.
  - Effective flags: live when FLAG_SRC=0, registered when FLAG_SRC=1.
- Condition codes: tcnd is combinational, and is 0 whenever br_en=0.
  - 0: none, tcnd=0.
  - 1: RET, tcnd=(sp!=0).
  - 2: JUMP, tcnd=1.
  - 3: CALL, tcnd=(sp!=DEPTH).
  - 4: JZ, tcnd=Z.
  - 5: JNZ, tcnd=~Z.
  - 6: JC, tcnd=C.
  - 7: JNC, tcnd=~C.
  - 8: JN, tcnd=N.
  - 9: JNN, tcnd=~N.
  - 10–15: reserved, tcnd=0.
- br_addr: top-of-stack entry (stack[sp-1]) for RET; tgt_addr for all other codes. Value when tcnd=0 is don't-care but must be X-free.
- Stack, updated only when br_en=1:
  - CALL with sp<DEPTH: stack[sp]<=ret_addr, sp<=sp+1.
  - RET with sp>0: sp<=sp-1.
  - Single-cycle latency: a RET in the cycle right after a CALL returns the just-pushed address.
- Boundaries:
  - CALL at sp=DEPTH: no push, sp unchanged, tcnd=0, ovf<=1.
  - RET at sp=0: no pop, tcnd=0, unf<=1.
  - sp never wraps.
- err_clr=1 clears ovf and unf at the edge. If a new error occurs in the same cycle, the error wins (flag stays 1).
- Stack and flags are otherwise unaffected by codes other than 1 and 3.

Decomposition:
- Shared package holds the condition-code constants CC_NONE, CC_RET, CC_JMP, CC_CALL, CC_JZ, CC_JNZ, CC_JC, CC_JNC, CC_JN, CC_JNN, plus the 4-bit code width.
- One natural sub-module: ret_stack (parametrised LIFO with push/pop/full/empty/top, AW x DEPTH). Condition decode and flag registers stay in tcnd_v2.

Test Plan:
- Reset, then FLAG_SRC=0, br_en=1 with aluo=9'h000 then 9'h001 for contl=4 → tcnd=1 then 0; contl=5 → 0 then 1; aluo=9'h100 with contl=6 → 1, contl=7 → 0; aluo=9'h080 with contl=8 → 1; contl=12 → 0; br_en=0 with contl=2 → 0.
- FLAG_SRC=1: flag_we=1 with aluo=9'h000, then aluo=9'h1FF with flag_we=0, contl=4 → tcnd=1 (registered zf=1 used, live value ignored).
- DEPTH=4: CALL with ret_addr 8'h10, 8'h20, 8'h30, 8'h40 → sp=4; fifth CALL → tcnd=0, ovf=1, sp=4; four RETs → br_addr 8'h40, 8'h30, 8'h20, 8'h10 with tcnd=1 each; sp=0.
- RET at sp=0 → tcnd=0, unf=1; err_clr=1 alone → unf=0; err_clr=1 together with RET at sp=0 → unf stays 1.
- CALL in cycle n with ret_addr=8'h55, RET in cycle n+1 → br_addr=8'h55, sp back to 0.
- Push two entries, assert rst_n=0 in the same cycle as a CALL → sp=0, zf=cf=nf=0, ovf=unf=0; a subsequent RET → unf=1.
